// File: rtl/ama_riscv_spec_tracker.sv
// ama_riscv_spec_tracker
// In-order speculation tracker for up to SPEC_DEPTH in-flight predicted
// branches. Entries {pc, pred} are pushed from decode and retired from the
// head when EXE resolves the matching branch. A mispredict flushes all
// entries and pulses spec_wrong with the recovery direction.
// Optional build macro: SPEC_TRACKER_STATS_EN adds saturating hit, miss and
// full-stall counters with output ports stat_hits, stat_misses and
// stat_full_stalls.
module ama_riscv_spec_tracker #(
  parameter int unsigned SPEC_DEPTH = 4,
  parameter int unsigned PC_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enter_valid,
  input  logic [PC_W-1:0]               enter_pc,
  input  logic                          enter_pred,
  output logic                          enter_ready,
  input  logic                          res_valid,
  input  logic [PC_W-1:0]               res_pc,
  input  logic                          res_taken,
  input  logic                          hazard_exe,
  output logic                          resolve,
  output logic                          bp_hit,
  output logic                          spec_wrong,
  output logic [PC_W-1:0]               pc_cp,
  output logic                          cp_taken,
  output logic                          spec_active,
`ifdef SPEC_TRACKER_STATS_EN
  output logic [31:0]                   stat_hits,
  output logic [31:0]                   stat_misses,
  output logic [31:0]                   stat_full_stalls,
`endif
  output logic [$clog2(SPEC_DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(SPEC_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]       pc_q [SPEC_DEPTH];
  logic [SPEC_DEPTH-1:0] pred_q;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic [PC_W-1:0]       head_pc;
  logic                  head_pred;
  logic                  push;

  // Head-entry match, hit/miss classification and push acceptance.
  // Resolution is masked while rst is high so a reset never emits a flush.
  always_comb begin
    head_pc     = pc_q[head];
    head_pred   = pred_q[head];
    resolve     = !rst && res_valid && !hazard_exe && (count != '0) &&
                  (res_pc == head_pc) && (res_pc != '0);
    bp_hit      = resolve && (head_pred == res_taken);
    spec_wrong  = resolve && !bp_hit;
    enter_ready = ((count < CNT_W'(SPEC_DEPTH)) || bp_hit) && !spec_wrong;
    push        = enter_valid && enter_ready;
    cp_taken    = spec_wrong ? res_taken : 1'b0;
    // Stale entries survive a flush, so the checkpoint is gated by count.
    pc_cp       = (count != '0) ? head_pc : '0;
    spec_active = (count != '0);
    occupancy   = count;
  end

  // Circular buffer, pointers and occupancy; a flush overrides push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      pred_q <= '0;
      for (int unsigned i = 0; i < SPEC_DEPTH; i++) begin
        pc_q[i] <= '0;
      end
    end else if (spec_wrong) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_q[tail]   <= enter_pc;
        pred_q[tail] <= enter_pred;
        tail         <= tail + PTR_W'(1);
      end
      if (bp_hit) begin
        head <= head + PTR_W'(1);
      end
      unique case ({push, bp_hit})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SPEC_TRACKER_STATS_EN
  logic full_stall;

  // A stall is a refused enter outside a flush cycle.
  always_comb begin
    full_stall = enter_valid && !enter_ready && !spec_wrong;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits        <= '0;
      stat_misses      <= '0;
      stat_full_stalls <= '0;
    end else begin
      if (bp_hit && (stat_hits != '1)) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if (spec_wrong && (stat_misses != '1)) begin
        stat_misses <= stat_misses + 32'd1;
      end
      if (full_stall && (stat_full_stalls != '1)) begin
        stat_full_stalls <= stat_full_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_spec_tracker.sv
// Directed self-checking bench for ama_riscv_spec_tracker (SPEC_DEPTH=4).
module tb_ama_riscv_spec_tracker;

  logic        clk;
  logic        rst;
  logic        enter_valid;
  logic [31:0] enter_pc;
  logic        enter_pred;
  logic        enter_ready;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic        hazard_exe;
  logic        resolve;
  logic        bp_hit;
  logic        spec_wrong;
  logic [31:0] pc_cp;
  logic        cp_taken;
  logic        spec_active;
  logic [2:0]  occupancy;
`ifdef SPEC_TRACKER_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
  logic [31:0] stat_full_stalls;
`endif

  int tests;
  int fails;

  ama_riscv_spec_tracker #(.SPEC_DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .enter_valid(enter_valid), .enter_pc(enter_pc), .enter_pred(enter_pred),
    .enter_ready(enter_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .hazard_exe(hazard_exe),
    .resolve(resolve), .bp_hit(bp_hit), .spec_wrong(spec_wrong),
    .pc_cp(pc_cp), .cp_taken(cp_taken), .spec_active(spec_active),
`ifdef SPEC_TRACKER_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_full_stalls(stat_full_stalls),
`endif
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enter_valid = 1'b0; enter_pc = '0; enter_pred = 1'b0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; hazard_exe = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    enter_valid = 1'b1; enter_pc = pc; enter_pred = pred;
    step();
    enter_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs();
    step(); step();
    rst = 1'b0;
    #2;
    tests++; if (enter_ready !== 1'b1) begin fails++; $display("FAIL reset_enter_ready got %b exp 1", enter_ready); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    tests++; if (pc_cp !== 32'h0) begin fails++; $display("FAIL reset_pc_cp got %h exp 0", pc_cp); end
    tests++; if (spec_active !== 1'b0) begin fails++; $display("FAIL reset_spec_active got %b exp 0", spec_active); end
    res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      tests++; if ({resolve, bp_hit, spec_wrong} !== 3'b000) begin fails++; $display("FAIL idle_resolve cyc %0d got %b exp 000", i, {resolve, bp_hit, spec_wrong}); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_hit();
    push(32'h100, 1'b1);
    #2;
    tests++; if (occupancy !== 3'd1) begin fails++; $display("FAIL hit_occ_before got %0d exp 1", occupancy); end
    tests++; if (pc_cp !== 32'h100) begin fails++; $display("FAIL hit_pc_cp got %h exp 100", pc_cp); end
    res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1;
    #1;
    tests++; if ({resolve, bp_hit, spec_wrong, cp_taken} !== 4'b1100) begin fails++; $display("FAIL hit_flags got %b exp 1100", {resolve, bp_hit, spec_wrong, cp_taken}); end
    step(); clear_inputs(); #2;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL hit_occ_after got %0d exp 0", occupancy); end
    tests++; if (pc_cp !== 32'h0) begin fails++; $display("FAIL hit_pc_cp_empty got %h exp 0", pc_cp); end
  endtask

  task automatic test_mispredict();
    push(32'h100, 1'b0);
    push(32'h108, 1'b0);
    push(32'h110, 1'b1);
    #2;
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL mp_occ_before got %0d exp 3", occupancy); end
    res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1;
    enter_valid = 1'b1; enter_pc = 32'h118; enter_pred = 1'b1;
    #1;
    tests++; if ({resolve, bp_hit, spec_wrong, cp_taken} !== 4'b1011) begin fails++; $display("FAIL mp_flags got %b exp 1011", {resolve, bp_hit, spec_wrong, cp_taken}); end
    tests++; if (pc_cp !== 32'h100) begin fails++; $display("FAIL mp_pc_cp got %h exp 100", pc_cp); end
    tests++; if (enter_ready !== 1'b0) begin fails++; $display("FAIL mp_enter_ready got %b exp 0", enter_ready); end
    step(); clear_inputs(); #2;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL mp_occ_after got %0d exp 0", occupancy); end
    tests++; if (spec_active !== 1'b0) begin fails++; $display("FAIL mp_spec_active got %b exp 0", spec_active); end
    tests++; if (pc_cp !== 32'h0) begin fails++; $display("FAIL mp_enter_dropped pc_cp got %h exp 0", pc_cp); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] heads [4];
    logic [31:0] news  [4];
    logic [31:0] tmp;
    heads = '{32'h200, 32'h204, 32'h208, 32'h20C};
    news  = '{32'h210, 32'h214, 32'h218, 32'h21C};
    for (int i = 0; i < 4; i++) push(heads[i], 1'b1);
    #2;
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL full_occ got %0d exp 4", occupancy); end
    enter_valid = 1'b1; enter_pc = 32'h210; enter_pred = 1'b1;
    #1;
    tests++; if (enter_ready !== 1'b0) begin fails++; $display("FAIL full_enter_ready got %b exp 0", enter_ready); end
    step(); #2;
    tests++; if (occupancy !== 3'd4 || pc_cp !== 32'h200) begin fails++; $display("FAIL full_no_push occ %0d pc_cp %h exp 4 200", occupancy, pc_cp); end
    // Push-while-pop on a full tracker, four times: tail ends at index 0.
    for (int i = 0; i < 4; i++) begin
      enter_valid = 1'b1; enter_pc = news[i]; enter_pred = 1'b1;
      res_valid = 1'b1; res_pc = heads[i]; res_taken = 1'b1;
      #1;
      tests++; if ({bp_hit, enter_ready} !== 2'b11) begin fails++; $display("FAIL pwp_flags %0d got %b exp 11", i, {bp_hit, enter_ready}); end
      step(); clear_inputs(); #1;
      tmp = (i == 3) ? news[0] : heads[i+1];
      tests++; if (occupancy !== 3'd4 || pc_cp !== tmp) begin fails++; $display("FAIL pwp_state %0d occ %0d pc_cp %h exp 4 %h", i, occupancy, pc_cp, tmp); end
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (pc_cp !== news[i]) begin fails++; $display("FAIL drain_pc_cp %0d got %h exp %h", i, pc_cp, news[i]); end
      res_valid = 1'b1; res_pc = news[i]; res_taken = 1'b1;
      step(); clear_inputs(); #1;
    end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL drain_occ got %0d exp 0", occupancy); end
    push(32'h300, 1'b0);
    #2;
    tests++; if (pc_cp !== 32'h300 || occupancy !== 3'd1) begin fails++; $display("FAIL wrap_push pc_cp %h occ %0d exp 300 1", pc_cp, occupancy); end
    res_valid = 1'b1; res_pc = 32'h300; res_taken = 1'b0;
    step(); clear_inputs();
  endtask

  task automatic test_hazard();
    push(32'h100, 1'b1);
    push(32'h108, 1'b0);
    res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; hazard_exe = 1'b1;
    #2;
    tests++; if ({resolve, bp_hit, spec_wrong} !== 3'b000) begin fails++; $display("FAIL hazard_suppress got %b exp 000", {resolve, bp_hit, spec_wrong}); end
    step(); hazard_exe = 1'b0; res_pc = 32'h108;
    #2;
    tests++; if ({resolve, occupancy} !== {1'b0, 3'd2}) begin fails++; $display("FAIL younger_ignored resolve %b occ %0d exp 0 2", resolve, occupancy); end
    step(); res_pc = 32'h100;
    #2;
    tests++; if ({resolve, bp_hit, spec_wrong} !== 3'b110) begin fails++; $display("FAIL hazard_retry got %b exp 110", {resolve, bp_hit, spec_wrong}); end
    step(); clear_inputs(); #2;
    tests++; if (occupancy !== 3'd1 || pc_cp !== 32'h108) begin fails++; $display("FAIL hazard_after occ %0d pc_cp %h exp 1 108", occupancy, pc_cp); end
  endtask

  task automatic test_reset_mid();
    push(32'h400, 1'b1);
    push(32'h404, 1'b1);
    #2;
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL rmid_occ_before got %0d exp 3", occupancy); end
    rst = 1'b1;
    res_valid = 1'b1; res_pc = 32'h108; res_taken = 1'b1;
    #1;
    tests++; if (spec_wrong !== 1'b0) begin fails++; $display("FAIL rmid_no_flush got %b exp 0", spec_wrong); end
    step(); rst = 1'b0; clear_inputs(); #2;
    tests++; if (occupancy !== 3'd0 || spec_wrong !== 1'b0 || pc_cp !== 32'h0) begin fails++; $display("FAIL rmid_after occ %0d sw %b pc_cp %h exp 0 0 0", occupancy, spec_wrong, pc_cp); end
`ifdef SPEC_TRACKER_STATS_EN
    tests++; if ({stat_hits, stat_misses, stat_full_stalls} !== 96'h0) begin fails++; $display("FAIL rmid_stats got %0d %0d %0d exp 0 0 0", stat_hits, stat_misses, stat_full_stalls); end
`endif
    push(32'h500, 1'b1);
    #2;
    tests++; if (pc_cp !== 32'h500 || occupancy !== 3'd1) begin fails++; $display("FAIL rmid_repush pc_cp %h occ %0d exp 500 1", pc_cp, occupancy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_hit();
    test_mispredict();
    test_full_wrap();
    test_hazard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
